// File: rtl/dm_lsu_if.sv
// dm_lsu_if: bundles the request/response handshake and the word-indexed
// data memory port of the load/store unit.
// slave  = the load/store unit itself
// master = the core/memory side that drives requests and models memory
interface dm_lsu_if #(
    parameter int DM_AW = 7
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_op;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [1:0]        dm_DMWr;
    logic [DM_AW-1:0]  dm_addr;
    logic [31:0]       dm_din;
    logic [31:0]       dm_dout;

    modport slave (
        input  req_valid, req_we, req_op, req_addr, req_wdata, rsp_ready, dm_dout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, dm_DMWr, dm_addr, dm_din
    );

    modport master (
        output req_valid, req_we, req_op, req_addr, req_wdata, rsp_ready, dm_dout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, dm_DMWr, dm_addr, dm_din
    );
endinterface

// File: rtl/dm_lsu.sv
// dm_lsu: load/store initiator between the memory stage and a word-indexed
// data memory. Sub-word stores are done as read-modify-write of a full word.
// Optional feature macro: DM_LSU_RANGE_CHECK_EN
//   defined   -> any nonzero address bit above the memory range is an error
//   undefined -> upper address bits are ignored (addresses alias)
module dm_lsu #(
    parameter int DM_AW = 7
) (
    input  logic     clk,
    input  logic     rst,
    dm_lsu_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RSP  = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;

    logic [2:0]        op_r;
    logic              we_r;
    logic [DM_AW-1:0]  idx_r;
    logic [1:0]        off_r;
    logic [31:0]       wdata_r;
    logic [31:0]       rbuf;
    logic              err_r;

    logic              req_err;
    logic [31:0]       wr_word;
    logic [31:0]       load_data;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;

`ifndef DM_LSU_RANGE_CHECK_EN
    logic              unused_upper_addr;
    assign unused_upper_addr = ^bus.req_addr[31:DM_AW+2];
`endif

    // Classify the incoming request as illegal before it is accepted
    always_comb begin
        req_err = 1'b0;
        case (bus.req_op)
            3'b000, 3'b100: req_err = 1'b0;
            3'b001, 3'b101: req_err = bus.req_addr[0];
            3'b010:         req_err = (bus.req_addr[1:0] != 2'b00);
            default:        req_err = 1'b1;
        endcase
        if (bus.req_we && bus.req_op[2]) begin
            req_err = 1'b1;
        end
`ifdef DM_LSU_RANGE_CHECK_EN
        if (|bus.req_addr[31:DM_AW+2]) begin
            req_err = 1'b1;
        end
`endif
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Latch the request on accept and capture the memory word in RD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r    <= 3'b000;
            we_r    <= 1'b0;
            idx_r   <= '0;
            off_r   <= 2'b00;
            wdata_r <= 32'h0;
            err_r   <= 1'b0;
            rbuf    <= 32'h0;
        end else begin
            if (state == IDLE && bus.req_valid) begin
                op_r    <= bus.req_op;
                we_r    <= bus.req_we;
                idx_r   <= bus.req_addr[DM_AW+1:2];
                off_r   <= bus.req_addr[1:0];
                wdata_r <= bus.req_wdata;
                err_r   <= req_err;
            end
            if (state == RD) begin
                rbuf <= bus.dm_dout;
            end
        end
    end

    // Merge store data into the word read back, and extract load lanes
    always_comb begin
        wr_word = rbuf;
        case (op_r[1:0])
            2'b00:   wr_word[{off_r, 3'b000} +: 8]     = wdata_r[7:0];
            2'b01:   wr_word[{off_r[1], 4'b0000} +: 16] = wdata_r[15:0];
            default: wr_word = wdata_r;
        endcase

        lane_b = rbuf[{off_r, 3'b000} +: 8];
        lane_h = rbuf[{off_r[1], 4'b0000} +: 16];
        case (op_r)
            3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_data = {24'h0, lane_b};
            3'b101:  load_data = {16'h0, lane_h};
            default: load_data = rbuf;
        endcase
    end

    // Next-state and state-decoded outputs
    always_comb begin
        next_state    = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = 32'h0;
        bus.rsp_err   = 1'b0;
        bus.dm_DMWr   = 2'b00;
        bus.dm_addr   = '0;
        bus.dm_din    = 32'h0;

        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (req_err) begin
                        next_state = RSP;
                    end else if (bus.req_we && bus.req_op == 3'b010) begin
                        next_state = WR;
                    end else begin
                        next_state = RD;
                    end
                end
            end
            RD: begin
                bus.dm_addr = idx_r;
                next_state  = we_r ? WR : RSP;
            end
            WR: begin
                bus.dm_addr = idx_r;
                bus.dm_DMWr = 2'b01;
                bus.dm_din  = wr_word;
                next_state  = RSP;
            end
            RSP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = err_r;
                if (!we_r && !err_r) begin
                    bus.rsp_rdata = load_data;
                end
                if (bus.rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dm_lsu.sv
// tb_dm_lsu: scoreboard bench for dm_lsu. Expected responses come from a
// byte-level memory model and are queued at issue time; a monitor pops and
// compares on every response handshake.
module tb_dm_lsu;

    localparam int DM_AW = 7;
    localparam int WORDS = 1 << DM_AW;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memInit = 1'b1;
    int          readyMode = 1;

    logic [31:0] mem    [WORDS];
    logic [31:0] refMem [WORDS];
    int          writeCount;
    int          expWrites = 0;
    logic [DM_AW-1:0] wrAddrLog;
    logic [31:0] wrDataLog;

    exp_rsp_t    expQ[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    dm_lsu_if #(.DM_AW(DM_AW)) bus();

    dm_lsu #(.DM_AW(DM_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.dm_dout = mem[bus.dm_addr];

    function automatic logic [31:0] initPattern(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Data memory: any nonzero write control is counted as a write
    always @(posedge clk) begin
        if (memInit) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= initPattern(i);
            writeCount <= 0;
        end else if (bus.dm_DMWr != 2'b00) begin
            mem[bus.dm_addr] <= bus.dm_din;
            writeCount <= writeCount + 1;
            wrAddrLog  <= bus.dm_addr;
            wrDataLog  <= bus.dm_din;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    // Reference model
    function automatic logic modelErr(input logic we, input logic [2:0] op, input logic [31:0] addr);
        logic e;
        e = 1'b0;
        if (op == 3 || op == 6 || op == 7) e = 1'b1;
        if (we && (op == 4 || op == 5)) e = 1'b1;
        if ((op == 1 || op == 5) && (addr % 2 != 0)) e = 1'b1;
        if (op == 2 && (addr % 4 != 0)) e = 1'b1;
`ifdef DM_LSU_RANGE_CHECK_EN
        if (addr >= 32'(WORDS * 4)) e = 1'b1;
`endif
        return e;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] op, input logic [31:0] word, input int off);
        logic [31:0] byteVal;
        logic [31:0] halfVal;
        byteVal = (word >> (8 * off)) & 32'hFF;
        halfVal = (word >> (16 * (off / 2))) & 32'hFFFF;
        case (op)
            3'd0:    return (byteVal >= 128)   ? (byteVal | 32'hFFFFFF00) : byteVal;
            3'd1:    return (halfVal >= 32768) ? (halfVal | 32'hFFFF0000) : halfVal;
            3'd4:    return byteVal;
            3'd5:    return halfVal;
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] modelStore(input logic [2:0] op, input logic [31:0] word, input int off, input logic [31:0] wdata);
        logic [31:0] mask;
        case (op)
            3'd0: begin
                mask = 32'hFF << (8 * off);
                return (word & ~mask) | ((wdata & 32'hFF) << (8 * off));
            end
            3'd1: begin
                mask = 32'hFFFF << (16 * (off / 2));
                return (word & ~mask) | ((wdata & 32'hFFFF) << (16 * (off / 2)));
            end
            default: return wdata;
        endcase
    endfunction

    // rsp_ready driver: random, forced high, or forced low
    initial begin
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       bus.rsp_ready = ($urandom_range(0, 3) != 0);
                1:       bus.rsp_ready = 1'b1;
                default: bus.rsp_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pop and compare on every response handshake
    initial begin
        exp_rsp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.rsp_valid && bus.rsp_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_rsp actual=1 required=0");
                end else begin
                    e = expQ.pop_front();
                    checkOutput("rsp_rdata", bus.rsp_rdata, e.rdata);
                    checkOutput("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                end
            end
        end
    end

    task automatic issueReq(input logic we, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, output int expLat);
        exp_rsp_t e;
        int idx;
        int off;
        int guard;
        idx = int'((addr >> 2) % WORDS);
        off = int'(addr % 4);
        e.err   = modelErr(we, op, addr);
        e.rdata = 32'h0;
        if (e.err) begin
            expLat = 1;
        end else if (we) begin
            refMem[idx] = modelStore(op, refMem[idx], off, wdata);
            expWrites++;
            expLat = (op == 3'd2) ? 2 : 3;
        end else begin
            e.rdata = modelLoad(op, refMem[idx], off);
            expLat  = 2;
        end
        expQ.push_back(e);

        @(negedge clk);
        guard = 0;
        while (!bus.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL req_ready_timeout actual=0 required=1");
        end
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom);
        bus.req_op    = 3'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
    endtask

    task automatic waitValid(input int expLat);
        int lat;
        lat = 1;
        while (!bus.rsp_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("latency", 32'(lat), 32'(expLat));
    endtask

    task automatic waitHandshake();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!(bus.rsp_valid && bus.rsp_ready) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!(bus.rsp_valid && bus.rsp_ready)) begin
            checks++;
            errors++;
            $display("[TB] FAIL handshake_timeout actual=0 required=1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        int lat;
        issueReq(we, op, addr, wdata, lat);
        waitValid(lat);
        waitHandshake();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        checkOutput({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        checkOutput({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'h0);
        checkOutput({tag, "_rsp_err"},   32'(bus.rsp_err), 32'd0);
        checkOutput({tag, "_dm_DMWr"},   32'(bus.dm_DMWr), 32'd0);
        checkOutput({tag, "_dm_addr"},   32'(bus.dm_addr), 32'd0);
        checkOutput({tag, "_dm_din"},    bus.dm_din, 32'h0);
    endtask

    // Watchdog
    initial begin
        #300000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence
    initial begin
        int wc;
        int lat;
        logic [31:0] expHold;
        logic [31:0] addr;
        logic [2:0]  op;
        logic        we;

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_op    = 3'b000;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        for (int i = 0; i < WORDS; i++) refMem[i] = initPattern(i);

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        memInit = 1'b0;
        rst     = 1'b0;
        $display("[TB] reset released");

        // Word store then load
        applyStimulus(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        checkOutput("sw_wr_addr", 32'(wrAddrLog), 32'd4);
        checkOutput("sw_wr_data", wrDataLog, 32'hDEADBEEF);
        applyStimulus(1'b0, 3'd2, 32'h10, 32'h0);

        // Byte store as read-modify-write, then signed/unsigned byte loads
        applyStimulus(1'b1, 3'd2, 32'h10, 32'h11223344);
        applyStimulus(1'b1, 3'd0, 32'h12, 32'h000000AA);
        checkOutput("sb_wr_data", wrDataLog, 32'h11AA3344);
        applyStimulus(1'b0, 3'd0, 32'h12, 32'h0);
        applyStimulus(1'b0, 3'd4, 32'h12, 32'h0);

        // Halfword loads
        applyStimulus(1'b1, 3'd2, 32'h10, 32'h80007FFF);
        applyStimulus(1'b0, 3'd1, 32'h12, 32'h0);
        applyStimulus(1'b0, 3'd5, 32'h12, 32'h0);
        applyStimulus(1'b0, 3'd1, 32'h10, 32'h0);

        // Misaligned requests must not touch memory
        wc = writeCount;
        applyStimulus(1'b0, 3'd2, 32'h11, 32'h0);
        applyStimulus(1'b1, 3'd1, 32'h13, 32'h0000BEEF);
        applyStimulus(1'b1, 3'd4, 32'h14, 32'h00000012);
        applyStimulus(1'b0, 3'd7, 32'h14, 32'h0);
        checkOutput("err_no_write", 32'(writeCount), 32'(wc));

        // Held response with an ignored request pulse
        readyMode = 2;
        expHold = modelLoad(3'd0, refMem[4], 3);
        issueReq(1'b0, 3'd0, 32'h13, 32'h0, lat);
        waitValid(lat);
        wc = writeCount;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            checkOutput("hold_req_ready", 32'(bus.req_ready), 32'd0);
            checkOutput("hold_rsp_rdata", bus.rsp_rdata, expHold);
            if (i == 1) begin
                bus.req_valid = 1'b1;
                bus.req_we    = 1'b1;
                bus.req_op    = 3'd2;
                bus.req_addr  = 32'h20;
                bus.req_wdata = 32'hCAFEF00D;
            end else if (i == 2) begin
                bus.req_valid = 1'b0;
            end
        end
        readyMode = 1;
        waitHandshake();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("hold_no_accept", 32'(writeCount), 32'(wc));

        // Reset during the read phase of a byte store
        wc = writeCount;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_op    = 3'd0;
        bus.req_addr  = 32'h11;
        bus.req_wdata = 32'h00000055;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkResetOutputs("midrst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_no_write", 32'(writeCount), 32'(wc));
        applyStimulus(1'b0, 3'd2, 32'h10, 32'h0);

        // Upper address bits: error with range check, alias without
        applyStimulus(1'b0, 3'd2, 32'h200, 32'h0);
        applyStimulus(1'b0, 3'd2, 32'h80000010, 32'h0);
        applyStimulus(1'b1, 3'd0, 32'h00000405, 32'h00000077);

        // Randomized traffic with random response back-pressure
        readyMode = 0;
        repeat (200) begin
            we = 1'($urandom);
            op = 3'($urandom_range(0, 7));
            addr = (($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFFFE00) : 32'h0)
                 | (32'($urandom_range(0, WORDS - 1)) << 2)
                 | 32'($urandom_range(0, 3));
            applyStimulus(we, op, addr, $urandom);
        end
        readyMode = 1;
        repeat (4) @(posedge clk);
        @(negedge clk);

        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        checkOutput("write_count", 32'(writeCount), 32'(expWrites));
        for (int i = 0; i < WORDS; i++) begin
            checkOutput($sformatf("mem[%0d]", i), mem[i], refMem[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
